// File: rtl/hazard_unit_if.sv
// Hazard-controller bus: Decode/Execute status from the datapath towards the
// hazard unit, and stall/flush/forward controls plus event counters back.
interface hazard_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       RA1D;
  logic [3:0]       RA2D;
  logic [3:0]       WA3D;
  logic             RegWriteD;
  logic             MemtoRegD;
  logic             PCSrcD;
  logic             CondExE;
  logic             BranchTakenE;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCnt, FlushCnt
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage ARM pipeline. Shadows the register
// addresses and write controls of the instructions in Execute (_p0),
// Memory (_p1) and Writeback (_p2) and derives forwarding selects,
// Fetch/Decode stalls and Decode/Execute flushes, plus saturating
// stall/flush event counters.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input logic     clk,
  input logic     reset,
  hazard_if.slave hz
);

  // Execute-stage shadow
  logic [3:0] ra1_p0, ra2_p0, wa3_p0;
  logic       rw_p0, mtr_p0, pcs_p0;
  // Memory-stage shadow; the load flag is not carried here because no
  // hazard decision looks at a load once it has left Execute
  logic [3:0] wa3_p1;
  logic       rw_p1, pcs_p1;
  // Writeback-stage shadow
  logic [3:0] wa3_p2;
  logic       rw_p2, pcs_p2;

  logic             ldr_stall, pc_wr_pending, stall_f, flush_e;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    if (en && (v != {CNT_W{1'b1}}))
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    return v;
  endfunction

  // R15 reads come from PCPlus8D, so R15 is never forwarded; a Memory-stage
  // producer is younger than a Writeback one and wins.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                         input logic [3:0] wa_m,
                                         input logic       rw_m,
                                         input logic [3:0] wa_w,
                                         input logic       rw_w);
    if (ra == 4'hF)            return 2'b00;
    if (rw_m && (ra == wa_m))  return 2'b10;
    if (rw_w && (ra == wa_w))  return 2'b01;
    return 2'b00;
  endfunction

  // Combinational hazard detection from shadow state and live D/E inputs
  always_comb begin
    ldr_stall     = mtr_p0 & rw_p0 &
                    ((hz.RA1D == wa3_p0) | (hz.RA2D == wa3_p0));
    pc_wr_pending = hz.PCSrcD | pcs_p0 | pcs_p1;
    stall_f       = ldr_stall | pc_wr_pending;
    flush_e       = ldr_stall | hz.BranchTakenE;
  end

  assign hz.StallF    = stall_f;
  assign hz.StallD    = ldr_stall;
  assign hz.FlushD    = pc_wr_pending | pcs_p2 | hz.BranchTakenE;
  assign hz.FlushE    = flush_e;
  assign hz.ForwardAE = fwd_sel(ra1_p0, wa3_p1, rw_p1, wa3_p2, rw_p2);
  assign hz.ForwardBE = fwd_sel(ra2_p0, wa3_p1, rw_p1, wa3_p2, rw_p2);
  assign hz.StallCnt  = stall_cnt;
  assign hz.FlushCnt  = flush_cnt;

  // D -> E boundary: a flush loads an all-zero bubble
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      ra1_p0 <= 4'h0;
      ra2_p0 <= 4'h0;
      wa3_p0 <= 4'h0;
      rw_p0  <= 1'b0;
      mtr_p0 <= 1'b0;
      pcs_p0 <= 1'b0;
    end else begin
      ra1_p0 <= hz.RA1D;
      ra2_p0 <= hz.RA2D;
      wa3_p0 <= hz.WA3D;
      rw_p0  <= hz.RegWriteD;
      mtr_p0 <= hz.MemtoRegD;
      pcs_p0 <= hz.PCSrcD;
    end
  end

  // E -> M boundary: write controls survive only if the condition passed
  always_ff @(posedge clk) begin
    if (reset) begin
      wa3_p1 <= 4'h0;
      rw_p1  <= 1'b0;
      pcs_p1 <= 1'b0;
    end else begin
      wa3_p1 <= wa3_p0;
      rw_p1  <= rw_p0 & hz.CondExE;
      pcs_p1 <= pcs_p0 & hz.CondExE;
    end
  end

  // M -> W boundary: straight copy
  always_ff @(posedge clk) begin
    if (reset) begin
      wa3_p2 <= 4'h0;
      rw_p2  <= 1'b0;
      pcs_p2 <= 1'b0;
    end else begin
      wa3_p2 <= wa3_p1;
      rw_p2  <= rw_p1;
      pcs_p2 <= pcs_p1;
    end
  end

  // Saturating stall/flush event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= sat_inc(stall_cnt, stall_f);
      flush_cnt <= sat_inc(flush_cnt, flush_e);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed scenarios followed by random
// traffic, all predicted by an instruction-level pipeline model.
module tb_hazard_unit;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_if #(.CNT_W(CNT_W)) hz ();
  hazard_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .hz(hz));

  typedef struct packed {
    logic [3:0] ra1, ra2, wa3;
    logic       rw, mtr, pcs;
  } instr_t;

  typedef struct {
    logic             sf, sd, fd, fe;
    logic [1:0]       fa, fb;
    logic [CNT_W-1:0] sc, fc;
    bit               chk;
    string            tag;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model: pipe[0]=Execute, pipe[1]=Memory, pipe[2]=Writeback
  instr_t           pipe [3];
  logic [CNT_W-1:0] m_scnt, m_fcnt;
  bit               p_reset = 1'b1;
  instr_t           p_d     = '0;
  bit               p_cond  = 1'b0;
  bit               p_sf    = 1'b0;
  bit               p_fe    = 1'b0;

  function automatic instr_t mk(input logic [3:0] ra1, input logic [3:0] ra2,
                                input logic [3:0] wa3, input logic rw,
                                input logic mtr, input logic pcs);
    instr_t i;
    i.ra1 = ra1; i.ra2 = ra2; i.wa3 = wa3; i.rw = rw; i.mtr = mtr; i.pcs = pcs;
    return i;
  endfunction

  function automatic logic [1:0] fwd(input logic [3:0] ra);
    if (ra == 4'hF) return 2'b00;
    if (pipe[1].rw && pipe[1].wa3 == ra) return 2'b10;
    if (pipe[2].rw && pipe[2].wa3 == ra) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_tick();
    if (p_reset) begin
      for (int k = 0; k < 3; k++) pipe[k] = '0;
      m_scnt = '0;
      m_fcnt = '0;
    end else begin
      if (p_sf && m_scnt != CMAX) m_scnt = m_scnt + 1'b1;
      if (p_fe && m_fcnt != CMAX) m_fcnt = m_fcnt + 1'b1;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (!p_cond) begin
        pipe[1].rw  = 1'b0;
        pipe[1].mtr = 1'b0;
        pipe[1].pcs = 1'b0;
      end
      pipe[0] = p_fe ? instr_t'('0) : p_d;
    end
  endtask

  // One clock of stimulus: advance the model past the edge, drive the new
  // inputs and queue the outputs the DUT should show this cycle.
  task automatic step(input bit r, input instr_t d, input bit cond,
                      input bit br, input string tag);
    exp_t e;
    logic ldr, pend;
    @(posedge clk);
    model_tick();
    #1;
    reset           = r;
    hz.RA1D         = d.ra1;
    hz.RA2D         = d.ra2;
    hz.WA3D         = d.wa3;
    hz.RegWriteD    = d.rw;
    hz.MemtoRegD    = d.mtr;
    hz.PCSrcD       = d.pcs;
    hz.CondExE      = cond;
    hz.BranchTakenE = br;
    ldr  = pipe[0].mtr && pipe[0].rw &&
           (d.ra1 == pipe[0].wa3 || d.ra2 == pipe[0].wa3);
    pend = d.pcs || pipe[0].pcs || pipe[1].pcs;
    e.sf  = ldr | pend;
    e.sd  = ldr;
    e.fd  = pend | pipe[2].pcs | br;
    e.fe  = ldr | br;
    e.fa  = fwd(pipe[0].ra1);
    e.fb  = fwd(pipe[0].ra2);
    e.sc  = m_scnt;
    e.fc  = m_fcnt;
    e.chk = !r;
    e.tag = tag;
    sbq.push_back(e);
    p_reset = r; p_d = d; p_cond = cond; p_sf = e.sf; p_fe = e.fe;
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
  endtask

  // Monitor: every cycle the DUT presents a full output set
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.chk) begin
          check({e.tag, ".StallF"},    int'(hz.StallF),    int'(e.sf));
          check({e.tag, ".StallD"},    int'(hz.StallD),    int'(e.sd));
          check({e.tag, ".FlushD"},    int'(hz.FlushD),    int'(e.fd));
          check({e.tag, ".FlushE"},    int'(hz.FlushE),    int'(e.fe));
          check({e.tag, ".ForwardAE"}, int'(hz.ForwardAE), int'(e.fa));
          check({e.tag, ".ForwardBE"}, int'(hz.ForwardBE), int'(e.fb));
          check({e.tag, ".StallCnt"},  int'(hz.StallCnt),  int'(e.sc));
          check({e.tag, ".FlushCnt"},  int'(hz.FlushCnt),  int'(e.fc));
        end
      end
    end
  end

  initial begin
    instr_t nop, d;
    int     wait_cyc;
    nop = '0;
    hz.RA1D = '0; hz.RA2D = '0; hz.WA3D = '0;
    hz.RegWriteD = 1'b0; hz.MemtoRegD = 1'b0; hz.PCSrcD = 1'b0;
    hz.CondExE = 1'b0; hz.BranchTakenE = 1'b0;

    // Reset with busy D inputs, then idle
    step(1, mk(4'h3, 4'h5, 4'h7, 1, 1, 1), 1, 1, "rst");
    step(1, mk(4'h3, 4'h5, 4'h7, 1, 1, 1), 1, 1, "rst");
    step(0, nop, 0, 0, "rst_out");
    step(0, nop, 0, 0, "rst_out");

    // Memory-stage then Writeback-stage forward
    step(0, mk(4'h0, 4'h0, 4'h1, 1, 0, 0), 1, 0, "fwdM");
    step(0, mk(4'h1, 4'h4, 4'h5, 1, 0, 0), 1, 0, "fwdM");
    repeat (3) step(0, nop, 1, 0, "fwdM");
    step(1, nop, 1, 0, "rst");
    step(0, mk(4'h0, 4'h0, 4'h1, 1, 0, 0), 1, 0, "fwdW");
    step(0, nop, 1, 0, "fwdW");
    step(0, mk(4'h1, 4'h4, 4'h5, 1, 0, 0), 1, 0, "fwdW");
    repeat (3) step(0, nop, 1, 0, "fwdW");

    // Priority of M over W, and R15 never forwarded
    step(1, nop, 1, 0, "rst");
    step(0, mk(4'h0, 4'h0, 4'h2, 1, 0, 0), 1, 0, "prio");
    step(0, mk(4'h0, 4'h0, 4'h2, 1, 0, 0), 1, 0, "prio");
    step(0, mk(4'h3, 4'h2, 4'h6, 1, 0, 0), 1, 0, "prio");
    repeat (2) step(0, nop, 1, 0, "prio");
    step(0, mk(4'h0, 4'h0, 4'hF, 1, 0, 0), 1, 0, "r15");
    step(0, mk(4'hF, 4'hF, 4'h6, 1, 0, 0), 1, 0, "r15");
    repeat (3) step(0, nop, 1, 0, "r15");

    // Load-use: the dependent ADD is held in Decode for one extra cycle
    step(1, nop, 1, 0, "rst");
    step(0, mk(4'h0, 4'h0, 4'h3, 1, 1, 0), 1, 0, "ldr");
    step(0, mk(4'h0, 4'h3, 4'h4, 1, 0, 0), 1, 0, "ldr");
    step(0, mk(4'h0, 4'h3, 4'h4, 1, 0, 0), 1, 0, "ldr");
    repeat (4) step(0, nop, 1, 0, "ldr");

    // PC write through ResultW, condition passes then fails
    step(1, nop, 1, 0, "rst");
    step(0, mk(4'h0, 4'h0, 4'hF, 1, 1, 1), 1, 0, "pcw");
    repeat (5) step(0, nop, 1, 0, "pcw");
    step(1, nop, 1, 0, "rst");
    step(0, mk(4'h0, 4'h0, 4'hF, 1, 1, 1), 1, 0, "pcw_nc");
    step(0, nop, 0, 0, "pcw_nc");
    repeat (4) step(0, nop, 1, 0, "pcw_nc");

    // Taken branch, then counter saturation
    step(1, nop, 1, 0, "rst");
    step(0, nop, 1, 1, "br");
    step(0, nop, 1, 0, "br");
    repeat (20) step(0, nop, 1, 1, "sat");
    repeat (2) step(0, nop, 1, 0, "sat");

    // Random traffic over a small register set so hazards are frequent
    step(1, nop, 1, 0, "rst");
    for (int i = 0; i < 600; i++) begin
      d.ra1 = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
      d.ra2 = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
      d.wa3 = ($urandom_range(0, 7) == 7) ? 4'hF : 4'($urandom_range(0, 3));
      d.rw  = 1'($urandom_range(0, 3) != 0);
      d.mtr = 1'($urandom_range(0, 3) == 0);
      d.pcs = 1'($urandom_range(0, 11) == 0);
      step(($urandom_range(0, 59) == 0), d, 1'($urandom_range(0, 4) != 0),
           1'($urandom_range(0, 9) == 0), "rand");
    end
    step(0, nop, 1, 0, "tail");

    // Let the monitor drain the scoreboard, bounded
    wait_cyc = 0;
    while (sbq.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    n_checks++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL drain got %0d pending want 0", sbq.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
